ext_arbiter: RTL

Shares one 16-to-32-bit immediate extension unit between two requesters in the CPU pipeline. Each requester presents a 16-bit immediate and an extension mode through a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the extended result goes into a one-deep output register tagged with the winning requester's ID. Per-requester wrapping service counters are exported for debug and coverage.

---
 rtl/ext_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one 16->32-bit immediate extender between two
// requesters, with a one-deep tagged output register and per-requester counters.
module ext_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [15:0]      req0_imm,
  input  logic             req0_extop,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_imm,
  input  logic             req1_extop,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [31:0]      out_imm32,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned OUT_W = 32;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_imm32_q, out_imm32_d;
  logic             out_id_q, out_id_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             accept_c;
  logic             gnt_vld_c;
  logic             gnt_id_c;
  logic             xfer_c;
  logic [IMM_W-1:0] sel_imm_c;
  logic             sel_op_c;

  // Grant selection, handshake and next-state computation
  always_comb begin
    accept_c     = !out_valid_q || out_ready;
    gnt_vld_c    = req0_valid || req1_valid;
    // Under contention, the requester that did not win last time goes first
    gnt_id_c     = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
    xfer_c       = accept_c && gnt_vld_c;
    req0_ready   = xfer_c && !gnt_id_c;
    req1_ready   = xfer_c && gnt_id_c;
    sel_imm_c    = gnt_id_c ? req1_imm : req0_imm;
    sel_op_c     = gnt_id_c ? req1_extop : req0_extop;

    out_valid_d  = out_valid_q;
    out_imm32_d  = out_imm32_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (xfer_c) begin
      out_valid_d  = 1'b1;
      out_imm32_d  = {{IMM_W{sel_op_c & sel_imm_c[IMM_W-1]}}, sel_imm_c};
      out_id_d     = gnt_id_c;
      last_grant_d = gnt_id_c;
      if (gnt_id_c) cnt1_d = cnt1_q + CNT_W'(1);
      else          cnt0_d = cnt0_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_imm32_q  <= '0;
      out_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm32_q  <= out_imm32_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm32 = out_imm32_q;
  assign out_id    = out_id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule
